// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//
// Purpose:
//   Turns the PLL lock flag into the design-wide synchronous reset and a ready
//   status. Runs on the reference clock, which keeps running while the PLL is
//   unlocked. The flow is: synchronise lock, wait for a stable lock, hold reset
//   a little longer, then release. If lock never arrives within the timeout,
//   a PLL reset pulse is issued and the wait starts again. Lock-loss and
//   timeout events are counted (saturating) for debug LEDs/UART.
//
// Ports:
//   clk            in   1      reference clock
//   resetn         in   1      synchronous active-low reset
//   pll_locked     in   1      PLL lock flag, asynchronous to clk
//   pll_rst        out  1      active-high PLL reset request
//   sys_rst_n      out  1      synchronous active-low reset for downstream logic
//   ready          out  1      high while in RUN
//   lock_loss_cnt  out  CNT_W  saturating count of RUN -> lock-lost events
//   timeout_cnt    out  CNT_W  saturating count of lock timeouts
//   state          out  3      current state encoding
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT   = 2500000,
    parameter int PLL_RST_CYCLES = 25,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [2:0]       state
);

    // The shared dwell counter only has to reach (largest count - 1).
    localparam int MAX_SH  = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_TP  = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
    localparam int MAX_CNT = (MAX_SH > MAX_TP) ? MAX_SH : MAX_TP;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CW-1:0]    STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]    PLLRST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVT_MAX      = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        PLL_RST   = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk_s;
    logic                   loss_evt;
    logic                   timeout_evt;

    assign lk_s  = sync_q[SYNC_STAGES-1];
    assign state = state_q;

    // Next-state decision. Any lock drop before RUN is treated as a glitch and
    // simply restarts the wait; only a drop while in RUN counts as a lock loss.
    // The dwell counter restarts on every state change and freezes in RUN,
    // where it has no meaning. Undefined encodings fall back to WAIT_LOCK.
    always_comb begin
        state_d     = state_q;
        loss_evt    = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = PLL_RST;
                    timeout_evt = 1'b1;
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_d  = WAIT_LOCK;
                    loss_evt = 1'b1;
                end
            end
            PLL_RST: begin
                if (cnt_q == PLLRST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State, synchroniser and counters. The outputs are registered from the
    // next state so they change on the same edge as state and cannot glitch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q        <= '0;
            state_q       <= WAIT_LOCK;
            cnt_q         <= '0;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            pll_rst       <= 1'b0;
            lock_loss_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sys_rst_n <= (state_d == RUN);
            ready     <= (state_d == RUN);
            pll_rst   <= (state_d == PLL_RST);
            if (loss_evt && (lock_loss_cnt != EVT_MAX)) begin
                lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
            end
            if (timeout_evt && (timeout_cnt != EVT_MAX)) begin
                timeout_cnt <= timeout_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//
// Purpose:
//   Self-checking bench for pll_reset_sequencer. A driver issues directed and
//   random lock/reset patterns and pushes the expected outputs, computed from a
//   timing-rule model (lock streak length, wait time, pulse time left), into a
//   queue. A separate monitor pops one entry per clock and compares.
//
// Ports: none (top-level bench).
module tb_pll_reset_sequencer;

    localparam int SYNC    = 2;
    localparam int STABLE  = 8;
    localparam int HOLD    = 4;
    localparam int TIMEOUT = 50;
    localparam int PRST    = 5;
    localparam int CNT_W   = 8;
    localparam int RUN_AT  = STABLE + HOLD + 1;
    localparam int EVT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [2:0]       st;
        logic             prst;
        logic             srn;
        logic             rdy;
        logic [CNT_W-1:0] loss;
        logic [CNT_W-1:0] tmo;
    } exp_t;

    logic             clk;
    logic             resetn;
    logic             pll_locked;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic [CNT_W-1:0] timeout_cnt;
    logic [2:0]       state;

    int   checks;
    int   errors;
    exp_t expq[$];

    int   hist[SYNC];
    int   streak;
    int   wait_cycles;
    int   pulse_left;
    int   loss_m;
    int   tmo_m;

    pll_reset_sequencer #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLD),
        .LOCK_TIMEOUT  (TIMEOUT),
        .PLL_RST_CYCLES(PRST),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt),
        .timeout_cnt  (timeout_cnt),
        .state        (state)
    );

    // Free-running reference clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model for one clock edge. The FSM sees the input from SYNC
    // edges ago. A run of consecutive lock samples determines the phase:
    // 1..STABLE stable, next HOLD samples hold, beyond that run. A timeout
    // happens after TIMEOUT lock-free edges spent waiting, then the pulse
    // lasts PRST edges during which lock is ignored.
    task automatic modelStep(input logic rn, input logic lk, output exp_t e);
        int lks;
        if (!rn) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 0;
            streak      = 0;
            wait_cycles = 0;
            pulse_left  = 0;
            loss_m      = 0;
            tmo_m       = 0;
        end else begin
            lks = hist[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(lk);
            if (pulse_left > 0) begin
                pulse_left--;
            end else if (lks != 0) begin
                if (streak < RUN_AT) streak++;
                wait_cycles = 0;
            end else begin
                if (streak >= RUN_AT && loss_m < EVT_MAX) loss_m++;
                if (streak > 0) begin
                    wait_cycles = 0;
                end else begin
                    wait_cycles++;
                    if (wait_cycles == TIMEOUT) begin
                        pulse_left  = PRST;
                        wait_cycles = 0;
                        if (tmo_m < EVT_MAX) tmo_m++;
                    end
                end
                streak = 0;
            end
        end
        if (pulse_left > 0)              e.st = 3'd4;
        else if (streak == 0)            e.st = 3'd0;
        else if (streak <= STABLE)       e.st = 3'd1;
        else if (streak <= STABLE+HOLD)  e.st = 3'd2;
        else                             e.st = 3'd3;
        e.prst = (e.st == 3'd4);
        e.srn  = (e.st == 3'd3);
        e.rdy  = (e.st == 3'd3);
        e.loss = CNT_W'(loss_m);
        e.tmo  = CNT_W'(tmo_m);
    endtask

    // Drive inputs for n edges; each drive pushes the expected outcome.
    task automatic applyStimulus(input logic rn, input logic lk, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            resetn     = rn;
            pll_locked = lk;
            modelStep(rn, lk, e);
            expq.push_back(e);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        exp_t a;
        a = '{st: state, prst: pll_rst, srn: sys_rst_n, rdy: ready,
              loss: lock_loss_cnt, tmo: timeout_cnt};
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL cycle_outputs t=%0t: got st=%0d prst=%b srn=%b rdy=%b loss=%0d tmo=%0d, expected st=%0d prst=%b srn=%b rdy=%b loss=%0d tmo=%0d",
                     $time, a.st, a.prst, a.srn, a.rdy, a.loss, a.tmo,
                     e.st, e.prst, e.srn, e.rdy, e.loss, e.tmo);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: one expected entry per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput(e);
            end
        end
    end

    // Driver: directed scenarios followed by randomised lock patterns.
    initial begin
        int found;
        int len;
        checks     = 0;
        errors     = 0;
        resetn     = 1'b0;
        pll_locked = 1'b0;

        $display("[TB] clean lock latency");
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 1);
        found = -1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (sys_rst_n && found < 0) found = k;
            applyStimulus(1'b1, 1'b1, 1);
        end
        checkValue("lock_to_release_edges", found, SYNC + STABLE + HOLD);

        $display("[TB] glitch during stable");
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 5);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 20);
        checkValue("glitch_loss_cnt", int'(lock_loss_cnt), 0);

        $display("[TB] lock loss in run and relock");
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 20);
        checkValue("run_loss_cnt", int'(lock_loss_cnt), 1);

        $display("[TB] reset mid-hold");
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 12);
        checkValue("state_before_reset", int'(state), 2);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 3);

        $display("[TB] timeout retries, lock toggling inside pulse, saturation");
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, TIMEOUT - SYNC);
        for (int i = 0; i < PRST; i++) applyStimulus(1'b1, logic'(i % 2 == 0), 1);
        applyStimulus(1'b1, 1'b0, 260 * (TIMEOUT + PRST));
        checkValue("timeout_cnt_saturated", int'(timeout_cnt), EVT_MAX);

        $display("[TB] random lock patterns");
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 49) == 0) begin
                applyStimulus(1'b0, logic'($urandom_range(0, 1)), 1);
            end else begin
                len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 70)
                                                  : $urandom_range(1, 16);
                applyStimulus(1'b1, logic'($urandom_range(0, 1)), len);
            end
        end

        @(posedge clk);
        #2;
        checkValue("scoreboard_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
